// File: rtl/yuv422_fb_reader.sv
// YUV422 frame-buffer read stage: BRAM address issue, 2-word FIFO, 4:2:2 pixel unpack.
// Optional YUV422_FB_RD_UNDERRUN_EN adds a sticky underrun_o flag.
//
// state   | meaning
// ST_IDLE | after reset, no BRAM reads issued
// ST_RUN  | continuous frame reading, wraps at LINES-1
module yuv422_fb_reader #(
  parameter int LINES = 16,
  parameter int DW    = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  output logic [$clog2(LINES)-1:0] rd_addr_o,
  input  logic [DW-1:0]            rd_d_i,
  output logic [15:0]              px_o,
  output logic                     px_valid_o,
  input  logic                     px_ready_i,
  output logic                     px_sof_o,
  output logic                     px_eol_o
`ifdef YUV422_FB_RD_UNDERRUN_EN
  ,
  output logic                     underrun_o
`endif
);

  localparam int AW = $clog2(LINES);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t        r_state;
  logic [AW-1:0] r_addr;
  logic          r_issue_q;
  logic          r_drop;
  logic          r_sof_tag_q;
  logic          r_eol_tag_q;
  logic [DW-1:0] r_word [2];
  logic [1:0]    r_sof_tag;
  logic [1:0]    r_eol_tag;
  logic          r_wr_ptr;
  logic          r_rd_ptr;
  logic [1:0]    r_cnt;
  logic          r_half;

  logic          w_issue;
  logic          w_push;
  logic          w_hs;
  logic          w_pop;
  logic          w_valid;
  logic [DW-1:0] w_head;

  // FIFO occupancy plus the read in flight never exceeds two words
  assign w_issue = (r_state == ST_RUN) && ((r_cnt + 2'(r_issue_q)) < 2'd2);
  assign w_push  = r_issue_q && !r_drop && !start_i;
  assign w_valid = (r_cnt != 2'd0);
  assign w_hs    = w_valid && px_ready_i;
  assign w_pop   = w_hs && r_half;
  assign w_head  = r_word[r_rd_ptr];

  assign rd_addr_o  = r_addr;
  assign px_valid_o = w_valid;
  assign px_o       = !w_valid ? 16'h0000 : (r_half ? w_head[31:16] : w_head[15:0]);
  assign px_sof_o   = w_valid && r_sof_tag[r_rd_ptr] && !r_half;
  assign px_eol_o   = w_valid && r_eol_tag[r_rd_ptr] && r_half;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_issue_q   <= 1'b0;
      r_drop      <= 1'b0;
      r_sof_tag_q <= 1'b0;
      r_eol_tag_q <= 1'b0;
      r_word[0]   <= '0;
      r_word[1]   <= '0;
      r_sof_tag   <= 2'b00;
      r_eol_tag   <= 2'b00;
      r_wr_ptr    <= 1'b0;
      r_rd_ptr    <= 1'b0;
      r_cnt       <= 2'd0;
      r_half      <= 1'b0;
    end else if (start_i) begin
      // a read issued this cycle returns stale data next cycle and must be dropped
      r_state   <= ST_RUN;
      r_addr    <= '0;
      r_issue_q <= w_issue;
      r_drop    <= w_issue;
      r_wr_ptr  <= 1'b0;
      r_rd_ptr  <= 1'b0;
      r_cnt     <= 2'd0;
      r_half    <= 1'b0;
    end else begin
      r_issue_q <= w_issue;
      if (w_issue) begin
        r_addr      <= (r_addr == AW'(LINES - 1)) ? '0 : r_addr + 1'b1;
        r_sof_tag_q <= (r_addr == '0);
        r_eol_tag_q <= (r_addr == AW'(LINES - 1));
      end
      if (r_issue_q) r_drop <= 1'b0;
      if (w_push) begin
        r_word[r_wr_ptr]    <= rd_d_i;
        r_sof_tag[r_wr_ptr] <= r_sof_tag_q;
        r_eol_tag[r_wr_ptr] <= r_eol_tag_q;
        r_wr_ptr            <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_cnt <= r_cnt + 2'(w_push) - 2'(w_pop);
      if (w_hs) r_half <= ~r_half;
    end
  end

`ifdef YUV422_FB_RD_UNDERRUN_EN
  logic [1:0] r_hold;
  logic       r_underrun;

  // the pipeline-fill cycles right after a start are not counted as underrun
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_hold     <= 2'd0;
      r_underrun <= 1'b0;
    end else if (start_i) begin
      r_hold     <= 2'd3;
      r_underrun <= 1'b0;
    end else begin
      if (r_hold != 2'd0) r_hold <= r_hold - 2'd1;
      if ((r_state == ST_RUN) && px_ready_i && !w_valid && (r_hold == 2'd0))
        r_underrun <= 1'b1;
    end
  end

  assign underrun_o = r_underrun;
`endif

endmodule

// File: doc/yuv422_fb_reader.md
# yuv422_fb_reader

Read-side stage of the YUV422 frame buffer. It sits directly downstream of the block RAM: it drives the BRAM read address and absorbs the one-cycle read latency. It unpacks each 32-bit word into two 16-bit YCbCr 4:2:2 pixels and presents them on a valid/ready stream toward the HDMI output path. Frames repeat continuously; `start_i` resynchronises the read pointer to word 0.

## Interface
- `LINES`, 16: words per frame; must equal the BRAM depth; each word holds 2 pixels.
- `DW`, 32: BRAM word width; fixed at 32.
- `clk_i` input 1: sole clock; BRAM shares it.
- `rst_ni` input 1: asynchronous, active-low reset.
- `start_i` input 1: single-cycle pulse; flush and restart at word 0.
- `rd_addr_o` output $clog2(LINES): BRAM read address.
- `rd_d_i` input 32: BRAM read data, valid the cycle after the address is sampled.
- `px_o` output 16: pixel, {chroma[7:0], luma[7:0]}.
- `px_valid_o` output 1: `px_o` valid.
- `px_ready_i` input 1: downstream accepts `px_o`.
- `px_sof_o` output 1: qualifies the first pixel of a frame (word 0, even half).
- `px_eol_o` output 1: qualifies the last pixel of a frame (word LINES-1, odd half).

## Operation
- Word layout: [7:0] Y0, [15:8] Cb, [23:16] Y1, [31:24] Cr.
  - Even pixel: {Cb, Y0}.
  - Odd pixel: {Cr, Y1}.
- States:
  - IDLE: after reset; no reads are issued. Goes to RUN on `start_i`.
  - RUN: continuous reading. `start_i` in RUN flushes and stays in RUN.
- Read issue:
  - A read is issued in a cycle when state is RUN and (FIFO occupancy + in-flight) < 2.
  - On issue, the `issue_q` in-flight flag is set for the next cycle and the address register is incremented.
  - The address wraps LINES-1 -> 0 with no gap.
  - `rd_addr_o` equals the address register, combinationally; it is held when no read is issued.
- Capture:
  - The cycle after an issue, `rd_d_i` is written into a 2-entry word FIFO tagged with its address-is-0 and address-is-LINES-1 bits.
  - Capture is skipped when a drop flag is set.
- Unpack:
  - `half_q` selects the even/odd pixel of the FIFO head.
  - `px_valid_o` = FIFO not empty.
  - Handshake = `px_valid_o` & `px_ready_i`. It toggles `half_q`; the FIFO pops when `half_q` = 1.
  - Push and pop in the same cycle are allowed; occupancy is unchanged.
- `px_sof_o` = head tagged word 0 & `half_q` = 0. `px_eol_o` = head tagged word LINES-1 & `half_q` = 1. Both are meaningful only while `px_valid_o` is high.
- `start_i` (any state), applied at the clock edge:
  - FIFO emptied, `half_q` = 0, address register = 0, state = RUN.
  - If a read is in flight, the drop flag is set so the stale word is discarded.
  - `start_i` overrides a simultaneous handshake and push.
- `px_o` and `px_valid_o` are stable while `px_valid_o` & !`px_ready_i`.

## Timing
- Reset values:
  - Outputs: `rd_addr_o` = 0, `px_valid_o` = 0, `px_sof_o` = 0, `px_eol_o` = 0, `px_o` = 0.
  - Internal: state IDLE, FIFO empty, `half_q` = 0, `issue_q` = 0, drop flag = 0.
- Startup:
  - `start_i` high in cycle 0.
  - Cycle 1: read of word 0 issued.
  - Cycle 2: `rd_d_i` captured.
  - Cycle 3: `px_valid_o` = 1 with `px_sof_o` = 1.
- Latency `start_i` -> first pixel: 3 cycles.
- Throughput: with `px_ready_i` held high, 1 pixel per cycle, indefinitely and across frame wrap, with no bubbles after the first pixel.
- Backpressure: the FIFO fills to 2 words and issue stops; no word is lost or duplicated.
- Reset asserted mid-frame: all state returns to reset values immediately (asynchronous); reading resumes only after the next `start_i`.

## Configuration
- `YUV422_FB_RD_UNDERRUN_EN` defined: adds output `underrun_o` (1 bit, reset 0).
  - `underrun_o` is sticky-set when state = RUN, `px_ready_i` = 1 and `px_valid_o` = 0, excluding the 3 cycles following `start_i`.
  - It is cleared by `start_i`.
- Macro undefined: the port and its logic are absent; behaviour is otherwise identical.

## Test plan
- BRAM word k = {8'hC0+k, 8'h10+k, 8'hB0+k, 8'h20+k}, LINES = 16, ready held high, `start_i` pulse:
  - first pixel 3 cycles later = 16'hB020 with sof;
  - second pixel = 16'hC010;
  - 32 pixels on consecutive cycles; eol on the 32nd;
  - 33rd pixel = 16'hB020 with sof.
- Ready toggled with a random 50% pattern: captured pixel sequence is identical to the ready-high case; `px_o` is stable whenever valid & !ready; `rd_addr_o` never advances with the FIFO full.
- Ready low for 20 cycles after the first pixel: exactly 2 words buffered; on release, pixels 0..31 appear in order with no duplicates.
- `start_i` issued mid-frame at pixel 13 while a read is in flight: no stale pixel is output; the next valid pixel is 16'hB020 with sof, 3 cycles later.
- `rst_ni` pulsed low mid-frame: `px_valid_o` falls asynchronously; no pixel is output until `start_i`.
- With `YUV422_FB_RD_UNDERRUN_EN`:
  - ready-high stream: `underrun_o` stays 0;
  - BRAM clock gated for 4 cycles in a stress bench: `underrun_o` = 1 until `start_i`.
